// File: rtl/mem_seq_driver_pkg.sv
// -----------------------------------------------------------------------------
// mem_seq_driver_pkg
//
// Shared definitions for the memory sequence driver and anything that needs
// to agree with it on encodings:
//   - 2-bit FSM state encodings and the matching state_t enum
//   - rw polarity constants (RW_WRITE / RW_READ)
//   - 16-entry hex-digit to 7-segment code table, active-high, bit order
//     {g,f,e,d,c,b,a}; the memory's display path uses the same table
//   - seg7_code() lookup helper
// -----------------------------------------------------------------------------
package mem_seq_driver_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ,
    S_DONE  = ST_DONE
  } state_t;

  // Memory rw pin polarity
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Segment codes indexed by hex digit. The concatenation lists digit F first
  // so that SEG7_TABLE[d] returns the code for digit d.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  function automatic logic [6:0] seg7_code(input logic [3:0] digit);
    return SEG7_TABLE[digit];
  endfunction

endpackage

// File: rtl/mem_seq_driver_seg7_encode.sv
// -----------------------------------------------------------------------------
// seg7_encode
//
// Purely combinational hex digit to 7-segment encoder (active-high segments,
// bit order {g,f,e,d,c,b,a}). Used by the driver's readback self-check to
// derive the code the memory should be displaying.
//
// Ports:
//   digit  in  4  hex digit
//   code   out 7  segment code
// -----------------------------------------------------------------------------
module seg7_encode
  import mem_seq_driver_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] code
);

  logic [6:0] table_code;

  assign table_code = seg7_code(digit);

  // One assignment per segment keeps each segment's decode cone separate.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_seg
      assign code[gi] = table_code[gi];
    end
  endgenerate

endmodule

// File: rtl/mem_seq_driver.sv
// -----------------------------------------------------------------------------
// mem_seq_driver
//
// Initiator for the 8x4 array memory. On an accepted start pulse it writes a
// pattern (base + address, modulo 2^WIDTH) into every word, one word per
// cycle, then reads every word back, holding each address for DWELL_CYCLES
// cycles so the memory's 7-segment output can be read by eye. A one-cycle
// DONE state ends the sequence.
//
// Optional feature, macro MEM_SEQ_SELF_CHECK_EN:
//   defined   - the returned segment code is compared with the expected digit
//               on the last dwell cycle of every address; a mismatch sets the
//               sticky err flag.
//   undefined - led_in is ignored, err is constant 0, no encoder is built.
//
// Ports:
//   clock         in   1          system clock, rising edge
//   reset         in   1          synchronous active-high reset
//   start         in   1          one-cycle start pulse (ignored unless IDLE)
//   pattern_base  in   WIDTH      pattern seed, captured on accepted start
//   led_in        in   7          segment code from the memory (led_out)
//   address       out  ADDR_BITS  memory address
//   data_out      out  WIDTH      memory write data
//   rw            out  1          0 = write, 1 = read
//   ensure        out  1          memory enable, active high
//   busy          out  1          WRITE or READ phase in progress
//   done          out  1          one-cycle completion pulse
//   err           out  1          sticky readback mismatch flag
// -----------------------------------------------------------------------------
module mem_seq_driver
  import mem_seq_driver_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int REG_NUM      = 8,
  parameter int ADDR_BITS    = 3,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     pattern_base,
  input  logic [6:0]           led_in,
  output logic [ADDR_BITS-1:0] address,
  output logic [WIDTH-1:0]     data_out,
  output logic                 rw,
  output logic                 ensure,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // Dwell counter only needs to reach DWELL_CYCLES-1.
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [ADDR_BITS-1:0] ADDR_LAST  = ADDR_BITS'(REG_NUM - 1);
  localparam logic [DW-1:0]        DWELL_LAST = DW'(DWELL_CYCLES - 1);

  state_t                state_reg, state_next;
  logic [ADDR_BITS-1:0]  addr_reg,  addr_next;
  logic [WIDTH-1:0]      base_reg,  base_next;
  logic [DW-1:0]         dwell_reg, dwell_next;
  logic                  err_reg,   err_next;

  // Digit stored at (and expected back from) the current address. The sum
  // is deliberately WIDTH bits wide so it wraps with no carry.
  logic [WIDTH-1:0]      pattern_word;
  logic                  mismatch;

  assign pattern_word = base_reg + WIDTH'(addr_reg);

`ifdef MEM_SEQ_SELF_CHECK_EN
  logic [6:0] expected_code;

  seg7_encode u_seg7_encode (
    .digit (pattern_word),
    .code  (expected_code)
  );

  assign mismatch = (led_in != expected_code);
`else
  // No comparator in this build; the returned code is intentionally dropped.
  logic unused_led_in;

  assign unused_led_in = ^led_in;
  assign mismatch      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      base_reg  <= '0;
      dwell_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      base_reg  <= base_next;
      dwell_reg <= dwell_next;
      err_reg   <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    base_next  = base_reg;
    dwell_next = dwell_reg;
    err_next   = err_reg;

    address    = addr_reg;
    data_out   = '0;
    rw         = RW_READ;
    ensure     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          base_next  = pattern_base;
          err_next   = 1'b0;
          addr_next  = '0;
          dwell_next = '0;
          state_next = S_WRITE;
        end
      end

      S_WRITE: begin
        ensure   = 1'b1;
        busy     = 1'b1;
        rw       = RW_WRITE;
        data_out = pattern_word;
        if (addr_reg == ADDR_LAST) begin
          addr_next  = '0;
          dwell_next = '0;
          state_next = S_READ;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end

      S_READ: begin
        ensure = 1'b1;
        busy   = 1'b1;
        if (dwell_reg == DWELL_LAST) begin
          // Memory output has been stable for the whole dwell; judge it now.
          if (mismatch) begin
            err_next = 1'b1;
          end
          dwell_next = '0;
          if (addr_reg == ADDR_LAST) begin
            addr_next  = '0;
            state_next = S_DONE;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign err = err_reg;

endmodule

// File: tb/tb_mem_seq_driver.sv
// -----------------------------------------------------------------------------
// tb_mem_seq_driver
//
// Scoreboard bench. Each accepted start pushes the full list of expected
// memory transactions (writes, dwell reads, done) with their cycle numbers;
// a negedge monitor pops one entry whenever the DUT shows ensure, busy or
// done. A behavioural 8x4 memory returns segment codes, optionally corrupted
// on one address. Works with or without MEM_SEQ_SELF_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_mem_seq_driver;

  localparam int WIDTH        = 4;
  localparam int REG_NUM      = 8;
  localparam int ADDR_BITS    = 3;
  localparam int DWELL_CYCLES = 4;

`ifdef MEM_SEQ_SELF_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [WIDTH-1:0]     pattern_base;
  logic [6:0]           led_in;
  logic [ADDR_BITS-1:0] address;
  logic [WIDTH-1:0]     data_out;
  logic                 rw;
  logic                 ensure;
  logic                 busy;
  logic                 done;
  logic                 err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_seq_driver #(
    .WIDTH        (WIDTH),
    .REG_NUM      (REG_NUM),
    .ADDR_BITS    (ADDR_BITS),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .start        (start),
    .pattern_base (pattern_base),
    .led_in       (led_in),
    .address      (address),
    .data_out     (data_out),
    .rw           (rw),
    .ensure       (ensure),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference segment table ----------------
  function automatic logic [6:0] seg7_ref(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // ---------------- behavioural memory ----------------
  logic [3:0] mem [REG_NUM];
  int         corrupt_addr = -1;
  logic [6:0] corrupt_mask = 7'h7F;

  initial begin
    for (int i = 0; i < REG_NUM; i++) mem[i] = 4'h0;
  end

  always @(posedge clk) begin
    if (ensure === 1'b1 && rw === 1'b0) mem[address] <= data_out;
  end

  always @* begin
    led_in = seg7_ref(mem[address]);
    if (ensure === 1'b1 && rw === 1'b1 && corrupt_addr == int'(address))
      led_in = led_in ^ corrupt_mask;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int         cyc;
    bit         is_done;
    logic [2:0] addr;
    logic [3:0] data;
    logic       rw;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (ensure === 1'b1 || done === 1'b1 || busy === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_txn cyc=%0d: got ensure=%0b busy=%0b done=%0b addr=%0d, required idle",
                 cyc, ensure, busy, done, address);
      end else begin
        e  = exp_q.pop_front();
        ok = (cyc == e.cyc) && (done === e.is_done) && (ensure === !e.is_done) &&
             (busy === !e.is_done) && (err === e.err);
        if (!e.is_done)
          ok = ok && (address === e.addr) && (data_out === e.data) && (rw === e.rw);
        if (ok)
          $display("txn ok cyc=%0d done=%0b addr=%0d data=%h rw=%0b err=%0b",
                   cyc, done, address, data_out, rw, err);
        else begin
          n_fail++;
          $display("FAIL txn cyc=%0d: got done=%0b busy=%0b addr=%0d data=%h rw=%0b err=%0b, required cyc=%0d done=%0b addr=%0d data=%h rw=%0b err=%0b",
                   cyc, done, busy, address, data_out, rw, err,
                   e.cyc, e.is_done, e.addr, e.data, e.rw, e.err);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end else begin
      $display("chk ok %s = %0h", name, got);
    end
  endtask

  task automatic check_idle(input string tag, input logic req_err);
    check({tag, "_ensure"},   32'(ensure),   32'd0);
    check({tag, "_rw"},       32'(rw),       32'd1);
    check({tag, "_address"},  32'(address),  32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'(req_err));
  endtask

  // One full sequence. busy_at / reset_at give the edge (relative to the
  // start-sampling edge) at which an extra start or a reset is sampled; 0 = none.
  task automatic run(input logic [3:0] b, input int corrupt, input int busy_at, input int reset_at);
    int   s;
    int   a;
    bit   aborted;
    bit   exp_err;
    exp_t e;
    @(posedge clk); #1;
    corrupt_addr = corrupt;
    corrupt_mask = 7'($urandom_range(1, 127));
    pattern_base = b;
    start        = 1'b1;
    s            = cyc + 1;
    exp_err      = FEAT && (corrupt >= 0);
    for (int k = 0; k < REG_NUM; k++) begin
      e.cyc = s + k; e.is_done = 1'b0; e.addr = 3'(k);
      e.data = 4'(int'(b) + k); e.rw = 1'b0; e.err = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < REG_NUM * DWELL_CYCLES; k++) begin
      a = k / DWELL_CYCLES;
      e.cyc = s + REG_NUM + k; e.is_done = 1'b0; e.addr = 3'(a);
      e.data = 4'h0; e.rw = 1'b1; e.err = exp_err && (a > corrupt);
      exp_q.push_back(e);
    end
    e.cyc = s + REG_NUM + REG_NUM * DWELL_CYCLES; e.is_done = 1'b1;
    e.addr = 3'd0; e.data = 4'h0; e.rw = 1'b1; e.err = exp_err;
    exp_q.push_back(e);

    @(posedge clk); #1;
    start        = 1'b0;
    pattern_base = 4'($urandom);
    aborted      = 1'b0;
    for (int i = 1; i <= REG_NUM + REG_NUM * DWELL_CYCLES + 1 && !aborted; i++) begin
      start = (i == busy_at) || (i == reset_at);
      reset = (i == reset_at);
      if (start) pattern_base = ~b;
      @(posedge clk); #1;
      start = 1'b0;
      if (reset) begin
        reset = 1'b0;
        exp_q.delete();
        aborted = 1'b1;
        check_idle("after_reset", 1'b0);
      end
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    corrupt_addr = -1;
    check_idle(aborted ? "idle_aborted" : "idle_done", aborted ? 1'b0 : exp_err);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 32'(err), 32'(aborted ? 1'b0 : exp_err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    reset        = 1'b1;
    start        = 1'b1;   // start together with reset must be ignored
    pattern_base = 4'h9;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    check_idle("reset", 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("post_reset", 1'b0);

    run(4'h4, -1, 0, 0);           // basic: data 4..B
    run(4'hE, -1, 0, 0);           // wrap: E,F,0..5
    run(4'h7,  3, 0, 0);           // mismatch on address 3
    run(4'h2, -1, 0, 0);           // new start clears err
    run(4'h5, -1, 10, 0);          // start while busy ignored
    run(4'hA, -1, 0, 20);          // reset mid-read
    run(4'hC, -1, 0, 0);           // full sequence after reset
    for (int r = 0; r < 5; r++) begin
      c = $urandom_range(0, REG_NUM);
      run(4'($urandom), (c == REG_NUM) ? -1 : c, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
